wb_clint: RTL
=============

// Module: wb_clint
// PURPOSE
//  Core-local interruptor: a Wishbone classic responder on the CPU io port. It holds the
//  machine timer (mtime), the compare register (mtimecmp) and the software-interrupt bit
//  (msip). It drives the core's timer_interrupt and software_interrupt inputs.
//  external_interrupt stays with the existing interrupt helper.
// PARAMETERS
//  ADDR_WIDTH   6        word-address width of clint_addr
//  TICK_DIV     1        clk cycles per mtime increment (>=1; 1 = every cycle)
// PORTS
//  clk                 in   1   system clock, all state on rising edge
//  rst                 in   1   asynchronous, active-low reset
//  clint_addr          in   ADDR_WIDTH  word address
//  clint_dat_w         in   32  write data
//  clint_sel           in   4   byte lane enables, bit n = dat[8n+7:8n]
//  clint_cyc           in   1   bus cycle valid
//  clint_stb           in   1   strobe
//  clint_cti           in   3   cycle type, ignored (classic only)
//  clint_bte           in   2   burst type, ignored
//  clint_we            in   1   1 = write
//  clint_dat_r         out  32  read data, valid while clint_ack=1
//  clint_ack           out  1   one-cycle acknowledge
//  clint_err           out  1   one-cycle error for unmapped address
//  timer_interrupt     out  1   registered, 1 when mtime >= mtimecmp (unsigned 64-bit)
//  software_interrupt  out  1   equals msip
// BEHAVIOUR
//  Reset (rst=0, async): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0.
//   All outputs are 0 during and after reset, including dat_r, ack, err and both interrupts.
//  Word map: 0 msip (bit0 only; bits 31:1 read 0, writes ignored); 1 reserved (err);
//   2 mtimecmp[31:0]; 3 mtimecmp[63:32]; 4 mtime[31:0]; 5 mtime[63:32];
//   6..2^ADDR_WIDTH-1 err.
//  Handshake:
//   - Request = cyc & stb & !ack & !err. It is registered, so ack or err rises exactly
//     1 cycle after the request is sampled.
//   - ack and err are high for exactly 1 cycle, never both at once. With stb held, the
//     next request is accepted the cycle after ack falls, giving a 2-cycle minimum period.
//   - Write side effects apply on the same edge that raises ack.
//   - Read data is captured on that edge, with sel ignored. dat_r returns to 0 when ack=0.
//   - err accesses have no side effects and return dat_r=0.
//   - cyc dropped: no new request is accepted. A response already registered still
//     completes its 1-cycle ack.
//  Byte writes: only lanes with sel[n]=1 update. sel=0 still acks with no change.
//  Prescaler:
//   - Counts 0..TICK_DIV-1. tick=1 when count==TICK_DIV-1; the count then wraps to 0.
//   - TICK_DIV=1 gives tick every cycle.
//   - On tick, mtime <= mtime+1 with 64-bit wrap: FFFF_FFFF_FFFF_FFFF -> 0.
//  Simultaneous tick and bus write to mtime lo/hi:
//   - The write wins for the addressed word, with no increment applied to that word.
//   - Writing lo: hi still receives the carry from the increment of the old lo.
//   - Writing hi: lo still increments normally.
//  Reading mtime lo then hi is not atomic. Software re-reads hi; no shadow register.
//  timer_interrupt: registered compare of the post-update mtime and mtimecmp, 1 cycle
//   behind the registers.
//   - It stays high until mtimecmp is raised above mtime or mtime wraps.
//   - A write to mtimecmp takes effect on the compare the next cycle.
//  software_interrupt follows msip directly, with no extra delay after the write edge.
//  Reset asserted mid-transaction: any pending ack or err is dropped and all state
//   returns to its reset values.
// TESTING
//  1 Reset release, TICK_DIV=1, no bus activity.
//    -> timer_interrupt=0. Reading word 4 after 10 cycles returns about 10 (exact: cycle-counted).
//  2 Write 0x1 to word 0 with sel=4'b0001.
//    -> ack 1 cycle later, software_interrupt=1. Write 0 clears it. Read word 0 returns 0.
//  3 Write word 3 = 0 then word 2 = 20, with mtime=0.
//    -> timer_interrupt rises in the cycle after mtime reaches 20.
//    -> Write word 3 = 1: timer_interrupt falls the next cycle.
//  4 Write mtime = 64'hFFFF_FFFF_FFFF_FFFE (word 5 then word 4), TICK_DIV=1.
//    -> mtime wraps to 0 two ticks later. The carry reaches the hi word correctly.
//  5 Access word 1 and word 7.
//    -> err=1 for 1 cycle, ack=0, no state change.
//    -> Held stb gives err then idle alternating, never continuous.
//  6 Write 0xAABBCCDD to word 2 with sel=4'b0100.
//    -> Only mtimecmp[23:16]=0xBB changes. Then assert rst mid-ack: ack=0 immediately
//       and mtimecmp returns to all-ones.

Source files
------------

// File: rtl/wb_clint.sv
// Core-local interruptor: Wishbone classic slave holding mtime, mtimecmp and msip.
// Latency: ack/err 1 cycle after request; no backpressure, one access per 2 cycles with stb held.
module wb_clint #(
  parameter int ADDR_WIDTH = 6,
  parameter int TICK_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] clint_addr,
  input  logic [31:0]           clint_dat_w,
  input  logic [3:0]            clint_sel,
  input  logic                  clint_cyc,
  input  logic                  clint_stb,
  input  logic [2:0]            clint_cti,
  input  logic [1:0]            clint_bte,
  input  logic                  clint_we,
  output logic [31:0]           clint_dat_r,
  output logic                  clint_ack,
  output logic                  clint_err,
  output logic                  timer_interrupt,
  output logic                  software_interrupt
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    merge = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) merge[8*i +: 8] = d[8*i +: 8];
  endfunction

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [63:0]   mtime, mtimecmp, mtime_inc, mtime_nxt;
  logic          msip;
  logic          req, mapped;
  logic          hit_msip, hit_cmp_lo, hit_cmp_hi, hit_mt_lo, hit_mt_hi;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign unused_bits = ^{clint_cti, clint_bte};

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));
  assign req  = clint_cyc & clint_stb & ~clint_ack & ~clint_err;

  assign hit_msip   = (clint_addr == ADDR_WIDTH'(0));
  assign hit_cmp_lo = (clint_addr == ADDR_WIDTH'(2));
  assign hit_cmp_hi = (clint_addr == ADDR_WIDTH'(3));
  assign hit_mt_lo  = (clint_addr == ADDR_WIDTH'(4));
  assign hit_mt_hi  = (clint_addr == ADDR_WIDTH'(5));
  assign mapped     = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_mt_lo | hit_mt_hi;

  always_comb begin
    rdata = 32'd0;
    if (hit_msip)   rdata = {31'd0, msip};
    if (hit_cmp_lo) rdata = mtimecmp[31:0];
    if (hit_cmp_hi) rdata = mtimecmp[63:32];
    if (hit_mt_lo)  rdata = mtime[31:0];
    if (hit_mt_hi)  rdata = mtime[63:32];
  end

  // A bus write replaces only the addressed word; the other half still sees the tick,
  // so writing lo keeps the carry out of the old lo going into hi.
  always_comb begin
    mtime_inc = mtime + 64'd1;
    mtime_nxt = tick ? mtime_inc : mtime;
    if (req & clint_we & hit_mt_lo)
      mtime_nxt[31:0] = merge(mtime[31:0], clint_dat_w, clint_sel);
    if (req & clint_we & hit_mt_hi)
      mtime_nxt[63:32] = merge(mtime[63:32], clint_dat_w, clint_sel);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt         <= '0;
      mtime           <= 64'd0;
      mtimecmp        <= '1;
      msip            <= 1'b0;
      clint_ack       <= 1'b0;
      clint_err       <= 1'b0;
      clint_dat_r     <= 32'd0;
      timer_interrupt <= 1'b0;
    end else begin
      pre_cnt   <= tick ? '0 : pre_cnt + PW'(1);
      mtime     <= mtime_nxt;
      clint_ack <= req & mapped;
      clint_err <= req & ~mapped;
      clint_dat_r <= (req & mapped & ~clint_we) ? rdata : 32'd0;
      if (req & clint_we & hit_cmp_lo)
        mtimecmp[31:0] <= merge(mtimecmp[31:0], clint_dat_w, clint_sel);
      if (req & clint_we & hit_cmp_hi)
        mtimecmp[63:32] <= merge(mtimecmp[63:32], clint_dat_w, clint_sel);
      if (req & clint_we & hit_msip & clint_sel[0])
        msip <= clint_dat_w[0];
      // Compares the registers as they stand, so the flag trails them by one cycle.
      timer_interrupt <= (mtime >= mtimecmp);
    end
  end

  assign software_interrupt = msip;

endmodule
